// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory and ALU, driving datapath selects, ALU control and enables.
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pcwrite,
    output logic               adrsrc,
    output logic               memwrite,
    output logic               irwrite,
    output logic [1:0]         resultsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         immsrc,
    output logic [2:0]         alucontrol,
    output logic               regwrite,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     cur_state;
    state_t     nxt_state;
    logic       pcupdate;
    logic       branch;
    logic [1:0] aluop;
    logic       irw_raw;
    logic       memw_raw;
    logic       regw_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH: nxt_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXECUTER;
                    OP_I:         nxt_state = S_EXECUTEI;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_JAL:       nxt_state = S_JAL;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR:   nxt_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt_state = S_MEMWB;
            S_MEMWB:    nxt_state = S_FETCH;
            S_MEMWRITE: nxt_state = S_FETCH;
            S_EXECUTER: nxt_state = S_ALUWB;
            S_EXECUTEI: nxt_state = S_ALUWB;
            S_ALUWB:    nxt_state = S_FETCH;
            S_BEQ:      nxt_state = S_FETCH;
            S_JAL:      nxt_state = S_ALUWB;
            default:    nxt_state = S_FETCH;
        endcase
    end

    // Moore decode of the state register; unused codes fall to all-zero.
    always_comb begin
        pcupdate  = 1'b0;
        branch    = 1'b0;
        aluop     = 2'b00;
        irw_raw   = 1'b0;
        memw_raw  = 1'b0;
        regw_raw  = 1'b0;
        adrsrc    = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        case (cur_state)
            S_FETCH: begin
                irw_raw   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcupdate  = 1'b1;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: adrsrc = 1'b1;
            S_MEMWB: begin
                resultsrc = 2'b01;
                regw_raw  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memw_raw = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            S_ALUWB: regw_raw = 1'b1;
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    // immsrc follows op in every state since DECODE and MEMADR both use extimm.
    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    assign pcwrite  = ~reset & (pcupdate | (branch & zero));
    assign irwrite  = ~reset & irw_raw;
    assign memwrite = ~reset & memw_raw;
    assign regwrite = ~reset & regw_raw;
    assign state    = STATE_W'(cur_state);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each supported instruction class
// through its state sequence and checks enables, selects and ALU control.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;

    mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol),
        .regwrite(regwrite), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_enables(input string tag, input logic [3:0] exp);
        chk(tag, {4'b0, pcwrite, memwrite, irwrite, regwrite}, {4'b0, exp});
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        #2;
        chk("rst_state", 8'(state), 8'd0);
        chk_enables("rst_enables", 4'b0000);
        chk("rst_alusrcb", 8'(alusrcb), 8'h2);
        chk("rst_resultsrc", 8'(resultsrc), 8'h2);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        // lw 0x00452183
        chk_enables("lw_fetch_en", 4'b1010);
        chk("lw_fetch_immsrc", 8'(immsrc), 8'h0);
        tick(); chk("lw_s1", 8'(state), 8'd1);
        chk("lw_decode_srca", 8'(alusrca), 8'h1);
        chk("lw_decode_srcb", 8'(alusrcb), 8'h1);
        chk_enables("lw_decode_en", 4'b0000);
        tick(); chk("lw_s2", 8'(state), 8'd2);
        chk("lw_memadr_srca", 8'(alusrca), 8'h2);
        chk("lw_memadr_alu", 8'(alucontrol), 8'h0);
        tick(); chk("lw_s3", 8'(state), 8'd3);
        chk("lw_memread_adr", 8'(adrsrc), 8'h1);
        chk_enables("lw_memread_en", 4'b0000);
        tick(); chk("lw_s4", 8'(state), 8'd4);
        chk("lw_memwb_res", 8'(resultsrc), 8'h1);
        chk_enables("lw_memwb_en", 4'b0001);
        chk("lw_immsrc", 8'(immsrc), 8'h0);
        tick(); chk("lw_s0", 8'(state), 8'd0);

        // sw, then reset in the middle of MEMWRITE
        op = 7'b0100011; funct3 = 3'b010; #1;
        chk("sw_immsrc", 8'(immsrc), 8'h1);
        tick(); chk("sw_s1", 8'(state), 8'd1);
        tick(); chk("sw_s2", 8'(state), 8'd2);
        tick(); chk("sw_s5", 8'(state), 8'd5);
        chk_enables("sw_memwrite_en", 4'b0100);
        chk("sw_memwrite_adr", 8'(adrsrc), 8'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_state", 8'(state), 8'd0);
        chk("rst_mid_memwrite", 8'(memwrite), 8'h0);
        chk_enables("rst_mid_en", 4'b0000);
        tick(); chk("rst_hold_state", 8'(state), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        #1;
        chk("rst_rel_irwrite", 8'(irwrite), 8'h1);

        // beq taken
        chk("beq_immsrc", 8'(immsrc), 8'h2);
        tick(); chk("beq1_s1", 8'(state), 8'd1);
        tick(); chk("beq1_s9", 8'(state), 8'd9);
        chk("beq1_alu", 8'(alucontrol), 8'h1);
        chk("beq1_pcwrite", 8'(pcwrite), 8'h1);
        zero = 1'b0; #1;
        chk("beq1_pcwrite_comb", 8'(pcwrite), 8'h0);
        tick(); chk("beq1_s0", 8'(state), 8'd0);
        // beq not taken
        tick(); chk("beq2_s1", 8'(state), 8'd1);
        tick(); chk("beq2_s9", 8'(state), 8'd9);
        chk("beq2_pcwrite", 8'(pcwrite), 8'h0);
        chk_enables("beq2_en", 4'b0000);
        tick(); chk("beq2_s0", 8'(state), 8'd0);

        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); chk("sub_s1", 8'(state), 8'd1);
        tick(); chk("sub_s6", 8'(state), 8'd6);
        chk("sub_alu", 8'(alucontrol), 8'h1);
        chk("sub_srcb", 8'(alusrcb), 8'h0);
        chk("sub_srca", 8'(alusrca), 8'h2);
        tick(); chk("sub_s8", 8'(state), 8'd8);
        chk_enables("sub_aluwb_en", 4'b0001);
        chk("sub_aluwb_res", 8'(resultsrc), 8'h0);
        tick(); chk("sub_s0", 8'(state), 8'd0);

        // addi with instr[30] set still adds
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick(); chk("addi_s7", 8'(state), 8'd7);
        chk("addi_alu", 8'(alucontrol), 8'h0);
        chk("addi_srcb", 8'(alusrcb), 8'h1);
        tick(); chk("addi_s8", 8'(state), 8'd8);
        tick(); chk("addi_s0", 8'(state), 8'd0);

        // R-type and
        op = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
        tick(); tick(); chk("and_alu", 8'(alucontrol), 8'h2);
        tick(); tick(); chk("and_s0", 8'(state), 8'd0);

        // slti
        op = 7'b0010011; funct3 = 3'b010;
        tick(); tick(); chk("slt_alu", 8'(alucontrol), 8'h5);
        funct3 = 3'b110; #1;
        chk("or_alu", 8'(alucontrol), 8'h3);
        tick(); tick(); chk("slt_s0", 8'(state), 8'd0);

        // jal
        op = 7'b1101111; #1;
        chk("jal_immsrc", 8'(immsrc), 8'h3);
        tick(); chk("jal_s1", 8'(state), 8'd1);
        tick(); chk("jal_s10", 8'(state), 8'd10);
        chk_enables("jal_en", 4'b1000);
        chk("jal_srca", 8'(alusrca), 8'h1);
        chk("jal_srcb", 8'(alusrcb), 8'h2);
        tick(); chk("jal_s8", 8'(state), 8'd8);
        chk_enables("jal_aluwb_en", 4'b0001);
        tick(); chk("jal_s0", 8'(state), 8'd0);

        // illegal opcode runs as a two-cycle NOP
        op = 7'b0000000;
        tick(); chk("ill_s1", 8'(state), 8'd1);
        chk_enables("ill_decode_en", 4'b0000);
        tick(); chk("ill_s0", 8'(state), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the RV32I core, intended to replace the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles over one shared memory and one ALU.
- Drives the immediate extender's immsrc and the datapath mux selects, ALU control and write enables.
- Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
- STATE_W, 4, width of state register and debug state port (fixed at 4; parameterised for debug visibility).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address select: 0 = PC, 1 = ALU result
- memwrite  output  1  data memory write enable
- irwrite  output  1  instruction register and oldPC enable
- resultsrc  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- alusrca  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- alusrcb  output  2  ALU B select: 00 = rs2, 01 = extimm, 10 = constant 4
- immsrc  output  2  to immediate extender: 00 = I, 01 = S, 10 = B, 11 = J
- alucontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- regwrite  output  1  register file write enable
- state  output  STATE_W  current state, debug only

Behaviour:
- Reset
  - Asynchronous, active-high; state <= FETCH immediately on assertion, and mid-instruction reset abandons the instruction.
  - While reset = 1, pcwrite, irwrite, memwrite and regwrite are forced to 0; all other outputs take their FETCH values.
  - First FETCH executes on the first rising clk edge after deassertion.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11-15 go to FETCH next cycle with all enables 0.
- Transitions (one clk each)
  - FETCH -> DECODE.
  - DECODE:
    - op 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH, no architectural write, executes as a NOP.
  - MEMADR: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - JAL -> ALUWB.
- Moore outputs per state; unlisted signals are 0.
  - FETCH: adrsrc 0, irwrite 1, alusrca 00, alusrcb 10, ALU add, resultsrc 10, pcupdate 1.
  - DECODE: alusrca 01, alusrcb 01, ALU add (branch target precompute).
  - MEMADR: alusrca 10, alusrcb 01, add.
  - MEMREAD: resultsrc 00, adrsrc 1.
  - MEMWB: resultsrc 01, regwrite 1.
  - MEMWRITE: resultsrc 00, adrsrc 1, memwrite 1.
  - EXECUTER: alusrca 10, alusrcb 00, aluop 10.
  - EXECUTEI: alusrca 10, alusrcb 01, aluop 10.
  - ALUWB: resultsrc 00, regwrite 1.
  - BEQ: alusrca 10, alusrcb 00, aluop 01, resultsrc 00, branch 1.
  - JAL: alusrca 01, alusrcb 10, add, resultsrc 00, pcupdate 1.
- pcwrite = pcupdate OR (branch AND zero), combinational on zero in BEQ.
- immsrc is combinational from op in every state (required because DECODE and MEMADR consume extimm):
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all others -> 00
- ALU decode
  - aluop 00 -> add; 01 -> sub.
  - aluop 10, by funct3:
    - 000: sub if op[5] AND funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
    - other funct3: add.
- Latencies in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.

Test Plan:
- Reset asserted mid-MEMWRITE (sw) -> state = 0 within same cycle without clk edge; memwrite = 0 at once; after release, irwrite = 1 in first cycle.
- lw 0x00452183 -> states 0,1,2,3,4,0; immsrc 00 throughout; regwrite = 1 only in MEMWB with resultsrc 01; adrsrc 1 in MEMREAD.
- sw (op 0100011) -> states 0,1,2,5,0; immsrc 01; memwrite = 1 exactly one cycle; regwrite never 1.
- beq, zero = 1 then repeat with zero = 0 -> states 0,1,9,0; immsrc 10; alucontrol 001 in BEQ; pcwrite in BEQ equals zero.
- R-type sub (funct3 000, funct7b5 1) -> alucontrol 001; I-type addi with instr[30] = 1 -> alucontrol 000; funct3 111 -> 010; funct3 010 -> 101.
- jal (op 1101111) -> states 0,1,10,8,0; immsrc 11; pcwrite 1 in JAL; regwrite 1 in ALUWB. Illegal op 0000000 -> states 0,1,0 with no write enables asserted.
